// File: rtl/effect_pkg.sv
// Shared types and constants for the effect sequencer slice.
package effect_pkg;

  localparam int PKG_D_WIDTH     = 24;
  localparam int PKG_MEM_D_WIDTH = 16;
  localparam int TRUNC_SHIFT     = PKG_D_WIDTH - PKG_MEM_D_WIDTH;

  typedef logic signed [PKG_MEM_D_WIDTH-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/effect_timeout_counter.sv
// Watchdog for one effect-path channel: counts enabled cycles and flags
// expiry on the TIMEOUT_CYCLES-th one, holding there until cleared.
module effect_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_limit;

  assign at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign expire_o = en_i && at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (en_i && !at_limit)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/effect_sequencer.sv
// Streams each channel of a captured frame through a shared effect module.
// Optional DRY_MIX_EN adds i_mix: averages wet and dry for processed channels.
module effect_sequencer
  import effect_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int D_WIDTH        = PKG_D_WIDTH,
  parameter int MEM_D_WIDTH    = PKG_MEM_D_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef DRY_MIX_EN
  input  logic                         i_mix,
`endif
  input  logic                         i_frame_valid,
  input  logic [CHANNELS*D_WIDTH-1:0]  i_frame_data,
  input  logic [CHANNELS-1:0]          i_bypass,
  output logic [MEM_D_WIDTH-1:0]       o_eff_data,
  output logic                         o_eff_valid,
  input  logic                         i_eff_ready,
  input  logic [MEM_D_WIDTH-1:0]       i_eff_data,
  input  logic                         i_eff_valid,
  output logic [CHANNELS*D_WIDTH-1:0]  o_frame_data,
  output logic                         o_frame_valid,
  output logic                         o_busy,
  output logic                         o_overrun,
  output logic                         o_timeout
);

  localparam int SHIFT = D_WIDTH - MEM_D_WIDTH;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e                        state_q, state_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [CHANNELS-1:0]           byp_q, byp_d;
  logic signed [MEM_D_WIDTH-1:0] dry_q [CHANNELS];
  logic signed [MEM_D_WIDTH-1:0] dry_d [CHANNELS];
  logic signed [MEM_D_WIDTH-1:0] res_q [CHANNELS];
  logic signed [MEM_D_WIDTH-1:0] res_d [CHANNELS];
  logic [CHANNELS*D_WIDTH-1:0]   frame_q, frame_d;
  logic                          fvld_q, overrun_q, overrun_d, timeout_q, timeout_d;
  logic                          adv, tmo_en, tmo_expire;
  logic signed [MEM_D_WIDTH-1:0] wet_s;
  logic                          unused_lsbs;

  assign unused_lsbs = ^i_frame_data;

`ifdef DRY_MIX_EN
  function automatic logic signed [MEM_D_WIDTH-1:0] mix_avg(
    input logic signed [MEM_D_WIDTH-1:0] wet,
    input logic signed [MEM_D_WIDTH-1:0] dry
  );
    logic signed [MEM_D_WIDTH:0] sum;
    sum = {wet[MEM_D_WIDTH-1], wet} + {dry[MEM_D_WIDTH-1], dry};
    return sum[MEM_D_WIDTH:1];
  endfunction

  assign wet_s = i_mix ? mix_avg(i_eff_data, dry_q[ch_q]) : i_eff_data;
`else
  assign wet_s = i_eff_data;
`endif

  effect_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (!tmo_en),
    .en_i    (tmo_en),
    .expire_o(tmo_expire)
  );

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    byp_d     = byp_q;
    dry_d     = dry_q;
    res_d     = res_q;
    overrun_d = overrun_q | (i_frame_valid && (state_q != ST_IDLE));
    timeout_d = timeout_q;
    adv       = 1'b0;
    tmo_en    = 1'b0;
    case (state_q)
      ST_IDLE: if (i_frame_valid) begin
        for (int c = 0; c < CHANNELS; c++)
          dry_d[c] = i_frame_data[c*D_WIDTH + SHIFT +: MEM_D_WIDTH];
        byp_d   = i_bypass;
        ch_d    = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (byp_q[ch_q]) begin
          res_d[ch_q] = dry_q[ch_q];
          adv         = 1'b1;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tmo_en = 1'b1;
        if (i_eff_ready) begin
          state_d = ST_WAIT;
        end else if (tmo_expire) begin
          res_d[ch_q] = dry_q[ch_q];
          timeout_d   = 1'b1;
          adv         = 1'b1;
        end
      end
      ST_WAIT: begin
        tmo_en = 1'b1;
        if (i_eff_valid) begin
          res_d[ch_q] = wet_s;
          adv         = 1'b1;
        end else if (tmo_expire) begin
          res_d[ch_q] = dry_q[ch_q];
          timeout_d   = 1'b1;
          adv         = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (adv) begin
      if (ch_q == CH_W'(CHANNELS - 1)) begin
        state_d = ST_DONE;
      end else begin
        ch_d    = ch_q + CH_W'(1);
        state_d = ST_LOAD;
      end
    end
    for (int c = 0; c < CHANNELS; c++)
      frame_d[c*D_WIDTH +: D_WIDTH] = D_WIDTH'($unsigned(res_d[c])) << SHIFT;
  end

  // Frame output is loaded on entry to DONE so it changes only with o_frame_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      byp_q     <= '0;
      frame_q   <= '0;
      fvld_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        dry_q[c] <= '0;
        res_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      byp_q     <= byp_d;
      dry_q     <= dry_d;
      res_q     <= res_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      fvld_q    <= (state_d == ST_DONE);
      if (state_d == ST_DONE)
        frame_q <= frame_d;
    end
  end

  assign o_eff_valid   = (state_q == ST_SEND);
  assign o_eff_data    = (state_q == ST_SEND) ? dry_q[ch_q] : '0;
  assign o_frame_data  = frame_q;
  assign o_frame_valid = fvld_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_overrun     = overrun_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_effect_sequencer.sv
// Directed bench for effect_sequencer: 2 channels, 16-cycle watchdog, echo-plus-one effect.
module tb_effect_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_vld;
  logic [47:0] frame_dat;
  logic [1:0]  bypass;
  logic [15:0] o_eff_data;
  logic        o_eff_valid;
  logic        eff_rdy;
  logic [15:0] eff_dat;
  logic        eff_vld;
  logic [47:0] o_frame_data;
  logic        o_frame_valid;
  logic        o_busy;
  logic        o_overrun;
  logic        o_timeout;

  int          n_vec = 0;
  int          n_err = 0;
  int          fcount = 0;
  int          xfers = 0;
  logic [47:0] last_frame = '0;
  bit          resp_en = 1'b1;
  bit          pending = 1'b0;
  logic [15:0] pend_dat = '0;

  localparam logic [47:0] FRAME_A = {24'h123456, 24'h0ABCDE};
  localparam logic [47:0] FRAME_B = {24'h7FFF00, 24'h800000};
  localparam logic [47:0] WET_A   = {24'h123500, 24'h0ABD00};
  localparam logic [47:0] DRY_A   = {24'h123400, 24'h0ABC00};

  always #20 clk = ~clk;

  effect_sequencer #(
    .CHANNELS      (2),
    .D_WIDTH       (24),
    .MEM_D_WIDTH   (16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef DRY_MIX_EN
    .i_mix        (1'b0),
`endif
    .i_frame_valid(frame_vld),
    .i_frame_data (frame_dat),
    .i_bypass     (bypass),
    .o_eff_data   (o_eff_data),
    .o_eff_valid  (o_eff_valid),
    .i_eff_ready  (eff_rdy),
    .i_eff_data   (eff_dat),
    .i_eff_valid  (eff_vld),
    .o_frame_data (o_frame_data),
    .o_frame_valid(o_frame_valid),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
    .o_timeout    (o_timeout)
  );

  // Effect model: answers sample+1 one cycle after each accepted transfer.
  always @(negedge clk) begin
    eff_vld = pending;
    eff_dat = pend_dat;
    pending = 1'b0;
    if (o_eff_valid && eff_rdy) begin
      xfers++;
      pending  = resp_en;
      pend_dat = o_eff_data + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (o_frame_valid) begin
      fcount++;
      last_frame = o_frame_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [47:0] data, input logic [1:0] byp);
    tick();
    frame_dat = data;
    bypass    = byp;
    frame_vld = 1'b1;
    tick();
    frame_vld = 1'b0;
  endtask

  task automatic wait_frame(input int max, output int elapsed);
    int f0;
    f0 = fcount;
    elapsed = 0;
    while (fcount == f0 && elapsed < max) begin
      tick();
      elapsed++;
    end
    if (fcount == f0) chk("frame_wait_expired", 64'(elapsed), 64'(max + 1));
  endtask

  task automatic wait_eff_valid(input int max);
    int n;
    n = 0;
    while (!o_eff_valid && n < max) begin
      tick();
      n++;
    end
    if (!o_eff_valid) chk("eff_valid_wait_expired", 64'(n), 64'(max + 1));
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int el, f0, x0;
    bit stable;
    reset = 1'b1; frame_vld = 1'b0; frame_dat = '0; bypass = '0; eff_rdy = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_eff_valid", 64'(o_eff_valid), 64'd0);
    chk("rst_eff_data", 64'(o_eff_data), 64'd0);
    chk("rst_frame_valid", 64'(o_frame_valid), 64'd0);
    chk("rst_frame_data", 64'(o_frame_data), 64'd0);
    chk("rst_overrun", 64'(o_overrun), 64'd0);
    chk("rst_timeout", 64'(o_timeout), 64'd0);
    reset = 1'b0;

    // Both channels through the effect
    f0 = fcount; x0 = xfers;
    send_frame(FRAME_A, 2'b00);
    wait_frame(60, el);
    chk("wet_frame", 64'(last_frame), 64'(WET_A));
    chk("wet_xfers", 64'(xfers - x0), 64'd2);
    repeat (3) tick();
    chk("wet_one_valid", 64'(fcount - f0), 64'd1);
    chk("wet_overrun", 64'(o_overrun), 64'd0);
    chk("wet_idle", 64'(o_busy), 64'd0);

    // Channel 0 bypassed
    x0 = xfers;
    send_frame(FRAME_A, 2'b01);
    wait_frame(60, el);
    chk("byp_frame", 64'(last_frame), 64'({24'h123500, 24'h0ABC00}));
    chk("byp_xfers", 64'(xfers - x0), 64'd1);

    // Backpressure: ready held low for 10 cycles
    eff_rdy = 1'b0;
    x0 = xfers;
    send_frame(FRAME_A, 2'b00);
    wait_eff_valid(10);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!o_eff_valid || o_eff_data !== 16'h0ABC) stable = 1'b0;
      tick();
    end
    chk("bp_held_stable", 64'(stable), 64'd1);
    chk("bp_no_xfer", 64'(xfers - x0), 64'd0);
    eff_rdy = 1'b1;
    tick();
    chk("bp_xfer_first_ready", 64'(xfers - x0), 64'd1);
    chk("bp_valid_dropped", 64'(o_eff_valid), 64'd0);
    wait_frame(60, el);
    chk("bp_frame", 64'(last_frame), 64'(WET_A));
    chk("bp_no_timeout", 64'(o_timeout), 64'd0);

    // Strobe during DONE is dropped
    f0 = fcount;
    send_frame(FRAME_A, 2'b00);
    el = 0;
    while (!o_frame_valid && el < 60) begin tick(); el++; end
    chk("done_reached", 64'(o_frame_valid), 64'd1);
    frame_dat = FRAME_B; frame_vld = 1'b1;
    tick();
    frame_vld = 1'b0;
    repeat (4) tick();
    chk("done_ovr_set", 64'(o_overrun), 64'd1);
    chk("done_one_frame", 64'(fcount - f0), 64'd1);
    chk("done_frame_a", 64'(last_frame), 64'(WET_A));
    chk("done_not_started", 64'(o_busy), 64'd0);

    // Reset in WAIT abandons the frame
    resp_en = 1'b0;
    f0 = fcount;
    send_frame(FRAME_A, 2'b00);
    wait_eff_valid(10);
    tick();
    reset = 1'b1;
    tick();
    chk("wrst_busy", 64'(o_busy), 64'd0);
    chk("wrst_eff_valid", 64'(o_eff_valid), 64'd0);
    chk("wrst_frame_valid", 64'(o_frame_valid), 64'd0);
    chk("wrst_frame_data", 64'(o_frame_data), 64'd0);
    chk("wrst_overrun", 64'(o_overrun), 64'd0);
    chk("wrst_timeout", 64'(o_timeout), 64'd0);
    reset = 1'b0;
    resp_en = 1'b1;
    repeat (20) tick();
    chk("wrst_no_frame", 64'(fcount - f0), 64'd0);

    // Second strobe 3 cycles after the first
    f0 = fcount;
    send_frame(FRAME_A, 2'b00);
    tick();
    send_frame(FRAME_B, 2'b00);
    chk("ovr3_set", 64'(o_overrun), 64'd1);
    wait_frame(60, el);
    repeat (20) tick();
    chk("ovr3_frame_a", 64'(last_frame), 64'(WET_A));
    chk("ovr3_one_frame", 64'(fcount - f0), 64'd1);

    // Effect never answers
    do_reset();
    resp_en = 1'b0;
    f0 = fcount;
    send_frame(FRAME_A, 2'b00);
    wait_frame(60, el);
    chk("tmo_within_bound", 64'(el <= 40), 64'd1);
    chk("tmo_flag", 64'(o_timeout), 64'd1);
    chk("tmo_dry_frame", 64'(last_frame), 64'(DRY_A));
    chk("tmo_one_frame", 64'(fcount - f0), 64'd1);
    chk("tmo_no_overrun", 64'(o_overrun), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/effect_sequencer.md
Name: effect_sequencer

Overview:
- Next-generation, parametrised effect-path controller in the 25 MHz effect clock domain.
- Accepts one multi-channel audio frame (CHANNELS samples of D_WIDTH bits) per input strobe.
- Truncates each channel to MEM_D_WIDTH and streams the channels one at a time through a shared effect module over a ready/valid handshake.
- Collects the results, restores them to D_WIDTH and emits the complete frame; adds per-channel bypass and a watchdog timeout on the effect path.

Parameters:
- CHANNELS, 2, number of audio channels per frame (1..8).
- D_WIDTH, 24, I2S sample width.
- MEM_D_WIDTH, 16, effect/memory sample width (≤ D_WIDTH).
- TIMEOUT_CYCLES, 1024, max clk cycles spent waiting on the effect module per channel.

Ports:
- clk  in  1  25 MHz effect clock.
- reset  in  1  synchronous, active-high reset.
- i_frame_valid  in  1  one-cycle strobe: i_frame_data holds a new frame.
- i_frame_data  in  CHANNELS*D_WIDTH  packed samples, channel 0 in LSBs.
- i_bypass  in  CHANNELS  per-channel bypass (1 = dry copy, effect skipped).
- o_eff_data  out  MEM_D_WIDTH  sample to effect module.
- o_eff_valid  out  1  o_eff_data valid.
- i_eff_ready  in  1  effect module accepts sample.
- i_eff_data  in  MEM_D_WIDTH  processed sample.
- i_eff_valid  in  1  i_eff_data valid (one-cycle strobe).
- o_frame_data  out  CHANNELS*D_WIDTH  processed frame.
- o_frame_valid  out  1  one-cycle strobe, o_frame_data updated.
- o_busy  out  1  frame in progress.
- o_overrun  out  1  sticky: frame dropped while busy.
- o_timeout  out  1  sticky: effect response timed out.

Behaviour:
- Reset values:
  - all outputs 0; FSM returns to IDLE from any state.
  - channel index, timeout counter and captured frame are cleared.
  - a mid-handshake transaction is abandoned; no frame is emitted.
- FSM states: IDLE, LOAD, SEND, WAIT, DONE.
- IDLE:
  - i_frame_valid=1: capture truncated samples (upper MEM_D_WIDTH bits of each channel) and i_bypass; set ch=0; go to LOAD.
- LOAD:
  - bypass[ch]=1: result[ch] := dry[ch], then advance.
  - otherwise go to SEND.
  - Advance rule: if ch=CHANNELS-1 go to DONE, else ch++ and stay in LOAD.
- SEND:
  - o_eff_valid=1, o_eff_data=dry[ch], held stable until i_eff_ready=1.
  - Transfer occurs on the cycle where valid and ready are both high; then go to WAIT with o_eff_valid deasserted in the next cycle.
- WAIT:
  - i_eff_valid=1: result[ch] := i_eff_data, then advance as in LOAD.
  - The timeout counter counts cycles spent in SEND+WAIT for the current channel.
  - On reaching TIMEOUT_CYCLES: result[ch] := dry[ch], set o_timeout, then advance.
  - A late i_eff_valid arriving after a timeout is ignored.
- DONE:
  - Each o_frame_data channel = {result[ch], (D_WIDTH-MEM_D_WIDTH) zeros}.
  - o_frame_valid=1 for exactly this cycle; go to IDLE.
- o_busy=1 in every state except IDLE.
- Overrun:
  - i_frame_valid in any state other than IDLE discards the frame and sets o_overrun.
  - This includes DONE; the accepted frame is unaffected.
- o_overrun and o_timeout clear only on reset.
- Latency:
  - All channels bypassed: strobe-to-o_frame_valid = CHANNELS+2 cycles.
  - Otherwise, per non-bypassed channel, add the handshake cycles plus the effect response time.
- i_eff_valid outside WAIT is ignored.

Optional Feature:
- Macro DRY_MIX_EN.
- Defined:
  - extra input i_mix (1 bit).
  - When i_mix=1, each non-bypassed result = arithmetic mean of wet and dry, computed as the signed sum in MEM_D_WIDTH+1 bits followed by an arithmetic right shift by 1 (rounds toward −∞).
  - Bypassed and timed-out channels stay dry.
- Undefined: port absent; results are pure wet.

Decomposition:
- Shared package effect_pkg:
  - FSM state enum.
  - typedef for a MEM_D_WIDTH signed sample.
  - constant for truncation shift (D_WIDTH-MEM_D_WIDTH).
- One natural sub-module: effect_timeout_counter (load/clear/expire, width $clog2(TIMEOUT_CYCLES+1)).

Test Plan:
- CHANNELS=2, bypass=00, effect echoes sample+1 with ready tied high; frame {ch1=24'h123456, ch0=24'h0ABCDE} -> o_frame_data {24'h123500, 24'h0ABD00}, one o_frame_valid, overrun=0.
- bypass=01 with the same frame -> ch0 = 24'h0ABC00 (dry) and exactly one o_eff_valid transfer (ch1).
- i_eff_ready low for 10 cycles -> o_eff_data stable and o_eff_valid held high throughout; transfer on the first ready cycle.
- Effect never answers, TIMEOUT_CYCLES=16 -> o_timeout=1, frame emitted with dry samples within 2*(16+3)+2 cycles.
- Second i_frame_valid 3 cycles after the first, and another during DONE -> o_overrun=1; only the first frame is output.
- reset asserted in WAIT -> all outputs 0 the next cycle, no o_frame_valid; a new frame is then processed normally.
